// File: rtl/video_render_multi_if.sv
// Pixel-path bundle between the fetch/timing logic and the pixel renderer.
interface video_render_multi_if #(
  parameter int unsigned FETCH_BYTES = 8,
  parameter int unsigned PIX_W       = 4
);
  logic [8*FETCH_BYTES-1:0] pic_bits;
  logic                     fetch_sync;
  logic                     cend;
  logic                     post_cbeg;
  logic                     int_start;
  logic [1:0]               mode;
  logic                     pixf_14;
  logic [3:0]               border;
  logic                     blank;
  logic [PIX_W-1:0]         pixels;

  // Timing/fetch side: drives the word, strobes and controls, receives pixels.
  modport master (
    output pic_bits, fetch_sync, cend, post_cbeg, int_start,
    output mode, pixf_14, border, blank,
    input  pixels
  );

  // Renderer side.
  modport slave (
    input  pic_bits, fetch_sync, cend, post_cbeg, int_start,
    input  mode, pixf_14, border, blank,
    output pixels
  );
endinterface

// File: rtl/video_render_multi.sv
// Multi-mode pixel renderer: ZX attribute, 16-colour and border modes,
// one registered pixel per pixel strobe, with frame-rate flash.
module video_render_multi #(
  parameter int unsigned FETCH_BYTES = 8,
  parameter int unsigned FLASH_BITS  = 5,
  parameter int unsigned PIX_W       = 4
) (
  input logic            clk,
  input logic            rst_n,
  video_render_multi_if.slave vif
);

  localparam int unsigned PN_W     = $clog2(2 * FETCH_BYTES);
  localparam int unsigned BI_W     = $clog2(FETCH_BYTES);
  localparam int unsigned ATTR_OFS = FETCH_BYTES / 4;

  typedef enum logic [1:0] {
    MODE_ZX     = 2'b00,
    MODE_16C    = 2'b01,
    MODE_BORDER = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  logic                  ena_pix_c;
  logic [PN_W-1:0]       pixnum;
  mode_e                 mode_q;
  logic [FLASH_BITS-1:0] flash_ctr;
  logic                  flash_c;
  logic [PIX_W-1:0]      pixels_q;

  logic [7:0]            byte_arr [FETCH_BYTES];
  logic [BI_W-1:0]       zx_idx_c;
  logic [BI_W-1:0]       attr_idx_c;
  logic [BI_W-1:0]       c16_idx_c;
  logic [7:0]            pix_byte_c;
  logic [7:0]            attr_byte_c;
  logic [7:0]            c16_byte_c;
  logic                  pix_bit_c;
  logic [3:0]            ink_c;
  logic [3:0]            paper_c;
  logic [3:0]            colour_c;

  // One pixel advance per clk even when both strobes coincide.
  assign ena_pix_c = vif.cend | (vif.pixf_14 & vif.post_cbeg);
  assign flash_c   = flash_ctr[FLASH_BITS-1];

  // Split the fetch word into addressable bytes.
  always_comb begin
    for (int k = 0; k < int'(FETCH_BYTES); k++) begin
      byte_arr[k] = vif.pic_bits[8*k +: 8];
    end
  end

  // Colour of the pixel at the current pixnum under the latched mode.
  always_comb begin
    zx_idx_c    = BI_W'(pixnum >> 3);
    attr_idx_c  = zx_idx_c + BI_W'(ATTR_OFS);
    c16_idx_c   = BI_W'(pixnum >> 1);
    pix_byte_c  = byte_arr[zx_idx_c];
    attr_byte_c = byte_arr[attr_idx_c];
    c16_byte_c  = byte_arr[c16_idx_c];
    pix_bit_c   = pix_byte_c[3'(3'd7 - pixnum[2:0])];
    ink_c       = {attr_byte_c[6], attr_byte_c[2:0]};
    paper_c     = {attr_byte_c[6], attr_byte_c[5:3]};
    colour_c    = vif.border;
    case (mode_q)
      MODE_ZX:  colour_c = (pix_bit_c ^ (flash_c & attr_byte_c[7])) ? ink_c : paper_c;
      MODE_16C: colour_c = pixnum[0] ? {c16_byte_c[7], c16_byte_c[5:3]}
                                     : {c16_byte_c[6], c16_byte_c[2:0]};
      default:  colour_c = vif.border;
    endcase
  end

  // Pixel counter, mode latch and output pixel, all advancing on ena_pix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixnum   <= '0;
      mode_q   <= MODE_BORDER;
      pixels_q <= '0;
    end else if (ena_pix_c) begin
      if (vif.fetch_sync) begin
        pixnum <= '0;
        mode_q <= mode_e'(vif.mode);
      end else begin
        pixnum <= pixnum + PN_W'(1);
      end
      pixels_q <= vif.blank ? '0 : PIX_W'(colour_c);
    end
  end

  // Frame counter whose MSB is the flash phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_ctr <= '0;
    end else if (vif.int_start) begin
      flash_ctr <= flash_ctr + FLASH_BITS'(1);
    end
  end

  assign vif.pixels = pixels_q;

endmodule

// File: tb/tb_video_render_multi.sv
// Directed bench for video_render_multi: ZX, flash, 16C, blank, pixf_14,
// mid-word mode change and mid-word reset.
module tb_video_render_multi;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [63:0] ZX_BITS    = 64'hFFFF_FFFF_3847_0180;
  localparam logic [63:0] ZXF_BITS   = 64'hFFFF_FFFF_B8C7_0180;
  localparam logic [63:0] C4F_BITS   = {8{8'h4F}};
  localparam logic [63:0] CVAR_BITS  = 64'h0123_4567_89AB_CDEF;

  // Expected pixels, pixel 0 in the most significant nibble.
  localparam logic [63:0] EXP_ZX     = 64'hF888_8888_7777_7770;
  localparam logic [63:0] EXP_ZXF    = 64'h8FFF_FFFF_0000_0007;
  localparam logic [63:0] EXP_C4F    = 64'hF1F1_F1F1_F1F1_F1F1;
  localparam logic [63:0] EXP_CVAR   = 64'hFDD9_3D19_F4D0_3410;
  localparam logic [63:0] EXP_CBLANK = 64'hFDD9_0019_F4D0_3410;

  video_render_multi_if #(.FETCH_BYTES(8), .PIX_W(4)) vif ();

  video_render_multi #(.FETCH_BYTES(8), .FLASH_BITS(5), .PIX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  always #18 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (vif.pixels === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, vif.pixels, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic fs, input logic c, input logic p);
    vif.fetch_sync = fs;
    vif.cend       = c;
    vif.post_cbeg  = p;
    @(posedge clk);
    #1;
    vif.fetch_sync = 1'b0;
    vif.cend       = 1'b0;
    vif.post_cbeg  = 1'b0;
  endtask

  task automatic int_pulses(input int n);
    repeat (n) begin
      vif.int_start = 1'b1;
      @(posedge clk);
      #1;
      vif.int_start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Sixteen pixel strobes starting at pixnum 0; the last carries fetch_sync.
  task automatic run_word(input string tag, input logic [63:0] exp,
                          input logic [15:0] blank_mask, input logic pixf,
                          input logic gap, input logic [1:0] mode_mid);
    logic c;
    logic p;
    vif.pixf_14 = pixf;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) vif.mode = mode_mid;
      vif.blank = blank_mask[i];
      if (pixf) begin
        c = (i % 2 == 0);
        p = (i % 2 == 1) || (i == 6);
      end else begin
        c = 1'b1;
        p = 1'b0;
      end
      strobe(i == 15, c, p);
      vif.blank = 1'b0;
      chk($sformatf("%s[%0d]", tag, i), exp[63-4*i -: 4]);
      if (gap && i == 7) begin
        // Stray fetch_sync/post_cbeg without a pixel strobe must be ignored.
        vif.fetch_sync = 1'b1;
        vif.post_cbeg  = 1'b1;
        idle(1);
        vif.fetch_sync = 1'b0;
        vif.post_cbeg  = 1'b0;
        idle(1);
        chk($sformatf("%s_hold", tag), exp[63-4*i -: 4]);
      end
    end
    vif.pixf_14 = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    vif.pic_bits   = ZX_BITS;
    vif.fetch_sync = 1'b0;
    vif.cend       = 1'b0;
    vif.post_cbeg  = 1'b0;
    vif.int_start  = 1'b0;
    vif.mode       = 2'b00;
    vif.pixf_14    = 1'b0;
    vif.border     = 4'h5;
    vif.blank      = 1'b0;

    idle(2);
    chk("reset_pixels", 4'h0);
    rst_n = 1'b1;

    // Latched mode is BORDER until the first fetch_sync.
    strobe(1'b0, 1'b1, 1'b0);
    chk("border_after_reset", 4'h5);
    vif.border = 4'hA;
    idle(2);
    chk("hold_no_ena", 4'h5);
    vif.border = 4'h5;
    strobe(1'b1, 1'b1, 1'b0);
    chk("sync_edge_border", 4'h5);

    run_word("zx", EXP_ZX, 16'h0000, 1'b0, 1'b1, 2'b00);

    vif.pic_bits = ZXF_BITS;
    int_pulses(16);
    run_word("zx_flash", EXP_ZXF, 16'h0000, 1'b0, 1'b0, 2'b00);

    int_pulses(16);
    run_word("zx_flash_wrap", EXP_ZX, 16'h0000, 1'b0, 1'b0, 2'b00);

    vif.pic_bits = ZX_BITS;
    run_word("mode_mid", EXP_ZX, 16'h0000, 1'b0, 1'b0, 2'b01);

    vif.pic_bits = C4F_BITS;
    run_word("c16_4f", EXP_C4F, 16'h0000, 1'b0, 1'b0, 2'b01);

    vif.pic_bits = CVAR_BITS;
    int_pulses(16);
    run_word("c16_var", EXP_CVAR, 16'h0000, 1'b0, 1'b0, 2'b01);
    run_word("c16_blank", EXP_CBLANK, 16'h0030, 1'b0, 1'b0, 2'b01);
    run_word("pixf", EXP_CVAR, 16'h0000, 1'b1, 1'b0, 2'b01);

    // Asynchronous reset in the middle of a word.
    repeat (5) strobe(1'b0, 1'b1, 1'b0);
    chk("pre_reset_pix4", 4'h3);
    #5 rst_n = 1'b0;
    #1 chk("reset_async", 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vif.mode     = 2'b00;
    vif.pic_bits = ZXF_BITS;
    strobe(1'b0, 1'b1, 1'b0);
    chk("rst_border_1", 4'h5);
    strobe(1'b1, 1'b1, 1'b0);
    chk("rst_border_sync", 4'h5);
    run_word("zx_after_reset", EXP_ZX, 16'h0000, 1'b0, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
